// File: rtl/job_seq.sv
// job_seq: one start pulse runs matrix load, N source blocks and result drain.
// Optional JOB_SEQ_PERF_EN builds the run-cycle performance counter.
module job_seq #(
  parameter int MAT_BEATS = 64,
  parameter int BLK_W     = 16,
  parameter int DST_LG2   = 3,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [BLK_W-1:0]  cfg_blocks,
  input  logic              src_valid,
  input  logic              src_ready,
  input  logic              src_fin,
  input  logic              dst_valid,
  input  logic              dst_ready,
  output logic              matw,
  output logic              run,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [PERF_W-1:0] perf_cycles
);

  localparam int MW = (MAT_BEATS > 1) ? $clog2(MAT_BEATS) : 1;
  localparam int DW = BLK_W + DST_LG2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MATW = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] LAST = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [MW-1:0] MAT_END = MW'(MAT_BEATS - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [BLK_W-1:0] blocks;
  logic [BLK_W-1:0] blk_cnt;
  logic [MW-1:0]    mat_cnt;
  logic [DW-1:0]    dst_cnt;
  logic [BLK_W-1:0] blk_end;
  logic [DW-1:0]    dst_end;
  logic             dst_beat;
  logic             go;
  logic             mat_hit;
  logic             fin_hit;
  logic             dst_hit;
  logic             src_unused;

  // The write side counts on valid alone, so src_ready is only observed.
  assign src_unused = src_ready;

  assign dst_beat = dst_valid & dst_ready;
  assign go       = (state == IDLE) & start & ~abort;
  assign blk_end  = blocks - 1'b1;
  assign dst_end  = {blocks, {DST_LG2{1'b0}}} - 1'b1;
  assign mat_hit  = src_valid & (mat_cnt == MAT_END);
  assign fin_hit  = src_fin & (blk_cnt == blk_end);
  assign dst_hit  = dst_beat & (dst_cnt == dst_end);

  always_comb begin
    state_nxt = state;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (go) state_nxt = MATW;
        MATW: if (mat_hit) state_nxt = GAP;
        GAP:  state_nxt = (blocks != '0) ? RUN : DONE;
        RUN:  if (fin_hit) state_nxt = dst_hit ? DONE : LAST;
        LAST: if (dst_hit) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      blocks  <= '0;
      blk_cnt <= '0;
      mat_cnt <= '0;
      dst_cnt <= '0;
      matw    <= 1'b0;
      run     <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      matw  <= (state_nxt == MATW);
      run   <= (state_nxt == RUN) || (state_nxt == LAST);
      last  <= (state_nxt == LAST);
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (go) begin
        blocks  <= cfg_blocks;
        blk_cnt <= '0;
        mat_cnt <= '0;
        dst_cnt <= '0;
      end else begin
        if (state == MATW && src_valid)
          mat_cnt <= mat_cnt + 1'b1;
        if (state == RUN && src_fin)
          blk_cnt <= blk_cnt + 1'b1;
        if ((state == RUN || state == LAST) && dst_beat)
          dst_cnt <= dst_cnt + 1'b1;
      end
    end
  end

`ifdef JOB_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_cnt;
  logic [PERF_W-1:0] perf_q;

  // Captured on the edge into DONE, so include this cycle's run.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
      perf_q   <= '0;
    end else begin
      if (go)
        perf_cnt <= '0;
      else if (run)
        perf_cnt <= perf_cnt + 1'b1;
      if (state_nxt == DONE && state != DONE)
        perf_q <= perf_cnt + PERF_W'(run);
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
